regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Multi-port general-purpose register file for the pipelined core.
- Adds the following to the single-port-write register file:
  - parametrised read and write port counts
  - same-cycle write-to-read bypass
  - hardwired-zero register x0
  - per-register pending-write scoreboard, used by issue logic to detect RAW hazards
- Sits between decode/issue (read, allocate) and write-back (write, release).

Parameters:
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers
DATA_WIDTH, 64, register width in bits
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 2, number of write-back ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy cleared combinationally; 0 = write visible next cycle

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
rd_addr  input  NUM_READ*ADDR_WIDTH  read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_READ*DATA_WIDTH  read data, combinational
rd_busy  output  NUM_READ  1 = indexed register has an outstanding writer
wr_en  input  NUM_WRITE  write-back enables
wr_addr  input  NUM_WRITE*ADDR_WIDTH  write-back indices
wr_data  input  NUM_WRITE*DATA_WIDTH  write-back data
alloc_en  input  1  issue marks alloc_addr as pending
alloc_addr  input  ADDR_WIDTH  destination being issued
pending_cnt  output  ADDR_WIDTH+1  number of busy registers, registered

Behaviour:
Reset (rst=1, asynchronous):
- all registers cleared to 0
- all busy bits cleared to 0
- pending_cnt = 0
- outputs follow the array combinationally, so rd_data=0 and rd_busy=0 while rst is held
Write:
- On posedge with wr_en[j]=1 and wr_addr[j]!=0: rf[wr_addr[j]] <= wr_data[j].
- Writes to x0 are discarded; x0 always reads 0 and is never busy.
- Two ports writing the same address in one cycle: the highest-index port wins, for both data and bypass.
Read:
- rd_data[i] = rf[rd_addr[i]].
- If BYPASS=1 and some wr_en[j] with wr_addr[j]==rd_addr[i]!=0, rd_data[i] = wr_data of the highest such j.
- Zero-cycle latency.
Scoreboard:
- busy[r] is set on posedge by alloc_en with alloc_addr=r (r!=0).
- busy[r] is cleared on posedge by any wr_en[j] with wr_addr[j]=r.
- Simultaneous alloc and write to the same r: alloc wins, busy stays 1. The old writer completed and a new writer is pending; data is still written.
- Alloc of an already-busy register keeps it busy. Only one writer per register is tracked; issue must not over-allocate.
- Write to a non-busy register is legal: data is written and busy stays 0.
- rd_busy[i] = busy[rd_addr[i]], except when BYPASS=1 and the register is being written this cycle. In that case rd_busy[i]=0, because the data is forwarded. Alloc in the same cycle does not affect the current-cycle rd_busy.
- rd_addr=0 gives rd_busy=0.
pending_cnt:
- Registered popcount of the busy bits, updated in the same cycle as busy.
- Range 0..2**ADDR_WIDTH-1, with no wrap.
- Maintained as a popcount, not as an up/down counter, so it is always consistent after reset.
Reset asserted mid-operation:
- Takes effect immediately.
- Any in-flight alloc or write in that cycle is lost.

Optional Feature:
REGFILE_TRACE_EN
- Defined: on every posedge where a write changes a register's value, print one line per changed register: "x<n> changed, from 0x<old>(<signed old>) to 0x<new>(<signed new>)".
- Defined, busy events: each alloc prints "x<n> alloc"; each release of a busy register prints "x<n> release".
- Not defined: no simulation output and no extra state; the block is fully synthesizable.

Test Plan:
1. Reset, then read all 32 indices on both ports -> rd_data=0 and rd_busy=0 everywhere; pending_cnt=0.
2. Write x5=0xDEAD_BEEF via port 0 while reading x5 on port 1 in the same cycle, BYPASS=1 -> rd_data[1]=0xDEADBEEF that cycle and the next cycle. With BYPASS=0 -> old value 0, then 0xDEADBEEF.
3. Write x0=0x1234 on both ports, and alloc x0 -> x0 reads 0, rd_busy=0, pending_cnt=0.
4. Both ports write x7 in one cycle: port0=0x11, port1=0x22 -> x7 reads 0x22, including the bypass value that cycle.
5. Alloc x3 -> next cycle rd_busy=1, pending_cnt=1. Then write x3=0x55 and alloc x3 in the same cycle -> x3=0x55, busy stays 1, pending_cnt=1. Write x3 again without alloc -> busy 0, pending_cnt=0.
6. Alloc x1, x2, x4, then assert rst mid-cycle -> busy bits and pending_cnt drop to 0 immediately; registers read 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with same-cycle write bypass, hardwired x0
// and a per-register pending-write scoreboard. Define REGFILE_TRACE_EN for write/busy tracing.
module regfile_mp_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic [NUM_WRITE-1:0]             wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
  input  logic                             alloc_en,
  input  logic [ADDR_WIDTH-1:0]            alloc_addr,
  output logic [ADDR_WIDTH:0]              pending_cnt
);
  localparam int unsigned NREG = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [NREG-1:0]       wr_hit;
  logic [DATA_WIDTH-1:0] wr_val [NREG];
  logic [ADDR_WIDTH:0]   busy_pop;
  logic [ADDR_WIDTH-1:0] ra [NUM_READ];

  // Per-register write resolution; later ports override earlier ones, x0 never hit.
  // Gated by rst so nothing forwards while reset is held.
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) wr_val[r] = '0;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (!rst && wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
        wr_hit[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        wr_val[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Release first, then allocate, so a same-cycle alloc keeps the register busy.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (alloc_en && alloc_addr != '0) busy_nxt[alloc_addr] = 1'b1;
    busy_pop = '0;
    for (int unsigned r = 0; r < NREG; r++)
      busy_pop = busy_pop + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) rf[r] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++)
        if (wr_hit[r]) rf[r] <= wr_val[r];
      busy        <= busy_nxt;
      pending_cnt <= busy_pop;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ra[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (BYPASS != 0 && wr_hit[ra[i]]) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_val[ra[i]];
        rd_busy[i]                          = 1'b0;
      end else begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rf[ra[i]];
        rd_busy[i]                          = busy[ra[i]];
      end
    end
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_hit[r] && wr_val[r] != rf[r])
          $display("x%0d changed, from 0x%h(%0d) to 0x%h(%0d)", r,
                   rf[r], $signed(rf[r]), wr_val[r], $signed(wr_val[r]));
        if (wr_hit[r] && busy[r])
          $display("x%0d release", r);
        if (alloc_en && alloc_addr == r[ADDR_WIDTH-1:0])
          $display("x%0d alloc", r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: one bypassing and one non-bypassing instance
// sharing stimulus, checked against an array-based model of the register file.
module tb_regfile_mp_sb;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [AW:0]      pending_b, pending_n;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_rf [32];
  bit            m_busy [32];

  always #5 clk = ~clk;

  regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_cnt(pending_b));

  regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_cnt(pending_n));

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_step();
    int a;
    if (rst) begin
      model_reset();
      return;
    end
    for (int j = 0; j < NW; j++) begin
      a = int'(wr_addr[j*AW +: AW]);
      if (wr_en[j] && a != 0) begin
        m_rf[a]   = wr_data[j*DW +: DW];
        m_busy[a] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != 0) m_busy[int'(alloc_addr)] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_data(int a, bit byp);
    logic [DW-1:0] v;
    if (rst || a == 0) return '0;
    v = m_rf[a];
    if (byp)
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_busy(int a, bit byp);
    if (rst || a == 0) return 1'b0;
    if (byp)
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_pending();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_wr(int j, int a, logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = a[AW-1:0];
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_alloc(int a);
    alloc_en = 1'b1;
    alloc_addr = a[AW-1:0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    rd_addr = '0;
    model_reset();
    #2;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a); set_rd(1, a);
      #1;
      checks++;
      if (rd_data_b !== '0 || rd_data_n !== '0) begin
        failures++;
        $display("FAIL reset_data x%0d: got %h / %h, expected 0", a, rd_data_b, rd_data_n);
      end
      checks++;
      if (rd_busy_b !== '0 || rd_busy_n !== '0) begin
        failures++;
        $display("FAIL reset_busy x%0d: got %b / %b, expected 0", a, rd_busy_b, rd_busy_n);
      end
    end
    checks++;
    if (pending_b !== '0 || pending_n !== '0) begin
      failures++;
      $display("FAIL reset_pending: got %0d / %0d, expected 0", pending_b, pending_n);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    set_idle();
    set_rd(0, 0); set_rd(1, 5);
    set_wr(0, 5, 64'hDEAD_BEEF);
    #1;
    checks++;
    if (rd_data_b[DW +: DW] !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h, expected deadbeef", rd_data_b[DW +: DW]);
    end
    checks++;
    if (rd_data_n[DW +: DW] !== 64'h0) begin
      failures++;
      $display("FAIL nobypass_same_cycle: got %h, expected 0", rd_data_n[DW +: DW]);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_data_b[DW +: DW] !== 64'hDEAD_BEEF || rd_data_n[DW +: DW] !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_next_cycle: got %h / %h, expected deadbeef",
               rd_data_b[DW +: DW], rd_data_n[DW +: DW]);
    end
  endtask

  task automatic test_x0();
    set_idle();
    set_rd(0, 0); set_rd(1, 0);
    set_wr(0, 0, 64'h1234); set_wr(1, 0, 64'h1234);
    set_alloc(0);
    #1;
    checks++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0) begin
      failures++;
      $display("FAIL x0_same_cycle: got data %h / %h busy %b / %b, expected 0",
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0) begin
      failures++;
      $display("FAIL x0_after: got data %h / %h busy %b / %b, expected 0",
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
    end
    checks++;
    if (pending_b !== '0 || pending_n !== '0) begin
      failures++;
      $display("FAIL x0_pending: got %0d / %0d, expected 0", pending_b, pending_n);
    end
  endtask

  task automatic test_same_addr();
    set_idle();
    set_rd(0, 7); set_rd(1, 0);
    set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22);
    #1;
    checks++;
    if (rd_data_b[0 +: DW] !== 64'h22) begin
      failures++;
      $display("FAIL same_addr_bypass: got %h, expected 22", rd_data_b[0 +: DW]);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_data_b[0 +: DW] !== 64'h22 || rd_data_n[0 +: DW] !== 64'h22) begin
      failures++;
      $display("FAIL same_addr_stored: got %h / %h, expected 22", rd_data_b[0 +: DW], rd_data_n[0 +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    set_idle();
    set_rd(0, 3); set_rd(1, 0);
    set_alloc(3);
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b0) begin
      failures++;
      $display("FAIL alloc_same_cycle_busy: got %b / %b, expected 0", rd_busy_b[0], rd_busy_n[0]);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1 || pending_b !== 1 || pending_n !== 1) begin
      failures++;
      $display("FAIL alloc_busy: got busy %b / %b cnt %0d / %0d, expected 1 and 1",
               rd_busy_b[0], rd_busy_n[0], pending_b, pending_n);
    end
    set_wr(0, 3, 64'h55);
    set_alloc(3);
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1 || rd_data_b[0 +: DW] !== 64'h55) begin
      failures++;
      $display("FAIL write_alloc_same_cycle: got busy %b / %b data %h, expected 0 / 1 data 55",
               rd_busy_b[0], rd_busy_n[0], rd_data_b[0 +: DW]);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b1 || pending_b !== 1 || pending_n !== 1 ||
        rd_data_b[0 +: DW] !== 64'h55 || rd_data_n[0 +: DW] !== 64'h55) begin
      failures++;
      $display("FAIL alloc_wins: got busy %b cnt %0d / %0d data %h / %h, expected 1, 1, 55",
               rd_busy_b[0], pending_b, pending_n, rd_data_b[0 +: DW], rd_data_n[0 +: DW]);
    end
    set_wr(1, 3, 64'h77);
    tick();
    set_idle();
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b0 || pending_b !== 0 || pending_n !== 0 ||
        rd_data_n[0 +: DW] !== 64'h77) begin
      failures++;
      $display("FAIL release: got busy %b / %b cnt %0d / %0d data %h, expected 0, 0, 77",
               rd_busy_b[0], rd_busy_n[0], pending_b, pending_n, rd_data_n[0 +: DW]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] got_d, exp_d;
    bit got_b, exp_b;
    int a;
    for (int n = 0; n < 400; n++) begin
      set_idle();
      for (int j = 0; j < NW; j++) begin
        if ($urandom_range(0, 2) != 0) begin
          a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
          set_wr(j, a, {$urandom, $urandom});
        end
      end
      if ($urandom_range(0, 1) != 0) set_alloc(int'($urandom_range(0, 7)));
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 3) == 0 && wr_en[0]) set_rd(p, int'(wr_addr[0 +: AW]));
        else set_rd(p, int'($urandom_range(0, 9)));
      end
      #1;
      for (int p = 0; p < NR; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        for (int d = 0; d < 2; d++) begin
          got_d = (d == 0) ? rd_data_b[p*DW +: DW] : rd_data_n[p*DW +: DW];
          exp_d = exp_data(a, d == 0);
          checks++;
          if (got_d !== exp_d) begin
            failures++;
            $display("FAIL rand_data n=%0d port%0d byp=%0d x%0d: got %h, expected %h",
                     n, p, d == 0, a, got_d, exp_d);
          end
          got_b = (d == 0) ? rd_busy_b[p] : rd_busy_n[p];
          exp_b = exp_busy(a, d == 0);
          checks++;
          if (got_b !== exp_b) begin
            failures++;
            $display("FAIL rand_busy n=%0d port%0d byp=%0d x%0d: got %b, expected %b",
                     n, p, d == 0, a, got_b, exp_b);
          end
        end
      end
      checks++;
      if (int'(pending_b) != exp_pending() || int'(pending_n) != exp_pending()) begin
        failures++;
        $display("FAIL rand_pending n=%0d: got %0d / %0d, expected %0d", n, pending_b, pending_n, exp_pending());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    set_alloc(1); tick();
    set_alloc(2); tick();
    set_alloc(4); set_wr(0, 9, 64'hABCD); tick();
    set_idle();
    set_rd(0, 1); set_rd(1, 9);
    #1;
    checks++;
    if (rd_busy_b[0] !== 1'b1 || int'(pending_b) != exp_pending() || rd_data_b[DW +: DW] !== 64'hABCD) begin
      failures++;
      $display("FAIL pre_reset: got busy %b cnt %0d data %h, expected 1, %0d, abcd",
               rd_busy_b[0], pending_b, rd_data_b[DW +: DW], exp_pending());
    end
    set_alloc(6);
    set_wr(1, 8, 64'h99);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pending_b !== '0 || pending_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0 ||
        rd_data_b !== '0 || rd_data_n !== '0) begin
      failures++;
      $display("FAIL mid_reset_immediate: got cnt %0d / %0d busy %b / %b data %h / %h, expected 0",
               pending_b, pending_n, rd_busy_b, rd_busy_n, rd_data_b, rd_data_n);
    end
    set_rd(1, 8);
    #1;
    checks++;
    if (rd_data_b[DW +: DW] !== '0) begin
      failures++;
      $display("FAIL reset_no_bypass: got %h, expected 0", rd_data_b[DW +: DW]);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    set_rd(0, 6); set_rd(1, 8);
    #1;
    checks++;
    if (rd_busy_b !== '0 || rd_busy_n !== '0 || rd_data_b !== '0 || rd_data_n !== '0 ||
        pending_b !== '0 || pending_n !== '0) begin
      failures++;
      $display("FAIL inflight_lost: got busy %b / %b data %h / %h cnt %0d / %0d, expected 0",
               rd_busy_b, rd_busy_n, rd_data_b, rd_data_n, pending_b, pending_n);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_same_addr();
    test_scoreboard();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
